// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter serialising NREQ requesters onto one registered NOT/XOR/NAND unit
module gate_op_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op_i,
  input  logic [W*NREQ-1:0] a_i,
  input  logic [W*NREQ-1:0] b_i,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [IDW-1:0] ptr, sel, pick;
  logic [1:0] op_r;
  logic [W-1:0] a_r, b_r, res;
  // scan from the lowest priority up so the earliest hit after ptr wins
  always_comb begin
    pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NREQ]) pick = IDW'((int'(ptr) + i) % NREQ);
  end
  always_comb res = op_r == 2'b00 ? ~a_r : op_r == 2'b01 ? a_r ^ b_r : op_r == 2'b10 ? ~(a_r & b_r) : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      gnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          sel <= pick;
          op_r <= op_i[2*pick +: 2];
          a_r <= a_i[W*pick +: W];
          b_r <= b_i[W*pick +: W];
          gnt <= NREQ'(1) << pick;
          state <= EXEC;
        end
        EXEC: begin
          gnt <= '0;
          rsp_valid <= 1'b1;
          rsp_data <= res;
          rsp_id <= sel;
          rsp_err <= &op_r;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr <= sel == IDW'(NREQ - 1) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter: directed and random checks of gate_op_arbiter against a transaction-level model
module tb_gate_op_arbiter;
  localparam int NREQ = 4;
  localparam int W = 2;
  localparam int IDW = $clog2(NREQ);
  logic clk = 0, rst = 1, rsp_ready = 0;
  logic [NREQ-1:0] req = '0;
  logic [2*NREQ-1:0] op_i = '0;
  logic [W*NREQ-1:0] a_i = '0, b_i = '0;
  logic [NREQ-1:0] gnt;
  logic rsp_valid, rsp_err, busy;
  logic [W-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  int tests = 0, fails = 0;

  gate_op_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  function automatic logic [W:0] gate_eval(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == 2'd0) return {1'b0, ~a};
    if (op == 2'd1) return {1'b0, a ^ b};
    if (op == 2'd2) return {1'b0, ~(a & b)};
    return {1'b1, {W{1'b0}}};
  endfunction

  // model: phase 0 = free, 1 = grant cycle, 2 = response offered
  int ph = 0, mptr = 0, msel = 0;
  bit armed = 0;
  logic [W-1:0] p_data, e_data;
  logic p_err, e_err;
  int e_id;
  always @(posedge clk) begin
    if (rst) begin
      ph = 0; mptr = 0; e_data = '0; e_id = 0; e_err = 0; armed = 1;
    end else if (ph == 0) begin
      if (req != 0) begin
        msel = rr_pick(req, mptr);
        {p_err, p_data} = gate_eval(op_i[2*msel +: 2], a_i[W*msel +: W], b_i[W*msel +: W]);
        ph = 1;
      end
    end else if (ph == 1) begin
      ph = 2; e_data = p_data; e_id = msel; e_err = p_err;
    end else if (rsp_ready) begin
      ph = 0; mptr = (msel + 1) % NREQ;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("m_gnt", gnt, ph == 1 ? 32'(1) << msel : 0);
    chk("m_valid", rsp_valid, ph == 2);
    chk("m_busy", busy, ph != 0);
    chk("m_data", rsp_data, e_data);
    chk("m_id", rsp_id, e_id);
    chk("m_err", rsp_err, e_err);
  end

  task automatic set_rq(input int k, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_i[2*k +: 2] = op;
    a_i[W*k +: W] = a;
    b_i[W*k +: W] = b;
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 10 && g == 0; i++) begin @(negedge clk); g = gnt; end
    chk("gnt_timeout", g != 0, 1);
  endtask

  task automatic wait_rsp();
    logic v = 0;
    for (int i = 0; i < 10 && !v; i++) begin @(negedge clk); v = rsp_valid; end
    chk("rsp_timeout", v, 1);
  endtask

  task automatic drain();
    logic d = 0;
    req = '0; rsp_ready = 1;
    for (int i = 0; i < 10 && !d; i++) begin @(negedge clk); d = !busy && !rsp_valid; end
    chk("drain_timeout", d, 1);
  endtask

  logic [NREQ-1:0] g, gs[5];
  int gc[5];
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_valid", rsp_valid, 0); chk("rst_gnt", gnt, 0);
    // basic XOR on requester 0
    rst = 0; set_rq(0, 2'b01, 2'b10, 2'b11); req = 4'b0001; rsp_ready = 1;
    @(negedge clk); chk("t1_gnt", gnt, 4'b0001); req = '0;
    @(negedge clk); chk("t1_valid", rsp_valid, 1); chk("t1_data", rsp_data, 2'b01);
    chk("t1_id", rsp_id, 0); chk("t1_err", rsp_err, 0);
    @(negedge clk); chk("t1_idle", busy, 0);
    // rotation with all requesting
    rst = 1; @(negedge clk); rst = 0; req = 4'b1111;
    begin
      int k = 0;
      for (int c = 1; c <= 15; c++) begin
        @(negedge clk);
        if (gnt != 0 && k < 5) begin gs[k] = gnt; gc[k] = c; k++; end
      end
      chk("t2_count", k, 5);
    end
    chk("t2_g0", gs[0], 4'b0001); chk("t2_g1", gs[1], 4'b0010); chk("t2_g2", gs[2], 4'b0100);
    chk("t2_g3", gs[3], 4'b1000); chk("t2_g4", gs[4], 4'b0001);
    for (int i = 1; i < 5; i++) chk("t2_gap", gc[i] - gc[i-1], 3);
    drain();
    // back-pressure on requester 1
    set_rq(1, 2'b10, 2'b11, 2'b01); req = 4'b0010; rsp_ready = 0;
    wait_gnt(g); chk("t3_gnt", g, 4'b0010); req = 4'b1111;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", rsp_valid, 1); chk("t3_data", rsp_data, 2'b10);
      chk("t3_id", rsp_id, 1); chk("t3_nognt", gnt, 0);
      @(negedge clk);
    end
    rsp_ready = 1; @(negedge clk); chk("t3_idle", busy, 0);
    @(negedge clk); chk("t3_next", gnt, 4'b0100);
    drain();
    // reserved opcode then NOT
    set_rq(2, 2'b11, 2'b10, 2'b01); req = 4'b0100;
    wait_gnt(g); req = '0; wait_rsp();
    chk("t4_err", rsp_err, 1); chk("t4_data", rsp_data, 2'b00);
    drain();
    set_rq(2, 2'b00, 2'b01, 2'b00); req = 4'b0100;
    wait_gnt(g); req = '0; wait_rsp();
    chk("t4b_err", rsp_err, 0); chk("t4b_data", rsp_data, 2'b10);
    drain();
    // reset while a response is pending
    set_rq(3, 2'b01, 2'b01, 2'b10); req = 4'b1000; rsp_ready = 0;
    wait_gnt(g); req = '0; wait_rsp();
    rst = 1; @(negedge clk); chk("t5_valid", rsp_valid, 0); chk("t5_busy", busy, 0);
    rst = 0; rsp_ready = 1; req = 4'b1010;
    wait_gnt(g); chk("t5_gnt", g, 4'b0010);
    drain();
    // operand change after capture
    set_rq(0, 2'b00, 2'b01, 2'b00); req = 4'b0001;
    wait_gnt(g); chk("t6_gnt", g, 4'b0001); set_rq(0, 2'b00, 2'b11, 2'b00); req = '0;
    wait_rsp(); chk("t6_data", rsp_data, 2'b10);
    drain();
    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = $urandom_range(0, 199) == 0;
      req = NREQ'($urandom);
      op_i = (2*NREQ)'($urandom); a_i = (W*NREQ)'($urandom); b_i = (W*NREQ)'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one NOT/XOR/NAND gate-evaluation unit among NREQ requesters.
- Each requester presents an opcode and two W-bit operands.
- The block grants one requester at a time, evaluates the operation through a single registered stage, and returns the result with the requester ID over a valid/ready response port.
- It sits in front of the primitive gate datapath and serialises all access to it.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 2, operand and result width in bits.
- IDW, $clog2(NREQ), width of the requester ID (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester request level.
- op_i  input  2*NREQ  per-requester opcode; requester k uses bits [2k+1:2k].
- a_i  input  W*NREQ  per-requester operand A; requester k uses slice k.
- b_i  input  W*NREQ  per-requester operand B; requester k uses slice k.
- gnt  output  NREQ  one-hot grant, one-cycle pulse.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by the consumer.
- rsp_data  output  W  operation result.
- rsp_id  output  IDW  index of the granted requester.
- rsp_err  output  1  reserved opcode flag.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE and the round-robin pointer ptr goes to 0.
  - Outputs: gnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0.
  - Reset overrides everything, including a pending response; that response is discarded with no handshake.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req is nonzero, select the first asserted index scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - Register that requester's op, a and b.
  - Next cycle: gnt[sel]=1 for exactly one cycle, and state goes to EXEC.
  - If req is zero, stay in IDLE.
- EXEC:
  - Compute from the captured operands:
    - op 00: ~a
    - op 01: a ^ b
    - op 10: ~(a & b)
    - op 11: reserved; rsp_data=0 and rsp_err=1
  - Next cycle: rsp_valid=1 with rsp_data, rsp_id=sel and rsp_err, and state goes to RESP.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_err stay stable until rsp_ready=1 on a clk edge.
  - On that handshake: rsp_valid goes to 0, ptr becomes (sel+1) mod NREQ, and state goes to IDLE.
- Latency:
  - Request sampled in IDLE at edge t.
  - gnt is high during cycle t+1.
  - rsp_valid is high from cycle t+2.
  - Minimum of 3 cycles per transaction when rsp_ready is held high, because IDLE is re-entered before the next selection.
- Request rules:
  - req, op_i, a_i and b_i are sampled only in IDLE.
  - Requests in EXEC/RESP are neither granted nor lost. A requester holds req until it sees its gnt pulse.
  - A requester that drops req before being selected is simply not granted.
  - Capturing operands at selection means later changes on a_i/b_i do not affect the result.
- Fairness: after requester k is served, k has the lowest priority in the next selection. A continuously requesting requester is served within NREQ transactions.
- rsp_ready while rsp_valid=0 is ignored.
- busy = (state != IDLE).
- Results are exact W-bit bitwise operations; there is no carry or extension.

Test Plan:
- Reset then req=4'b0001, op0=01, a0=2'b10, b0=2'b11:
  - gnt=0001 one cycle after sampling.
  - rsp_valid next cycle with rsp_data=2'b01, rsp_id=0, rsp_err=0.
- req=4'b1111 held, rsp_ready=1:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - One grant every 3 cycles.
- Back-pressure:
  - Setup: op1=10, a1=2'b11, b1=2'b01, rsp_ready=0 for 5 cycles.
  - rsp_valid stays high with rsp_data=2'b10, rsp_id=1, stable for 5 cycles.
  - No new gnt while waiting.
  - After rsp_ready=1, state returns to IDLE and ptr=2.
- Reserved op:
  - op2=11 gives rsp_err=1 and rsp_data=2'b00.
  - The following op2=00 with a2=2'b01 gives rsp_err=0 and rsp_data=2'b10.
- Reset mid-operation:
  - Assert rst while in RESP with rsp_valid=1.
  - Next cycle: rsp_valid=0, busy=0, ptr=0.
  - With req=4'b1010, requester 1 is granted first.
- Operand change after selection:
  - Change a_i of the granted requester during its gnt cycle.
  - rsp_data reflects the originally captured value.
